// File: rtl/dd_pkg.sv
// Shared definitions for the double-dabble BCD sequencer: state encoding,
// add-3 constants and the counter-width helper.
package dd_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADJ  = 2'd1;
    localparam logic [1:0] SHF  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    typedef enum logic [1:0] {
        StIdle = IDLE,
        StAdj  = ADJ,
        StShf  = SHF,
        StDone = DONE
    } dd_state_e;

    localparam logic [3:0] ADD3_THRESH = 4'd5;
    localparam logic [3:0] ADD3_VAL    = 4'd3;

    // Ceiling log2, never less than 1; call as clog2(BIN_W + 1).
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/dd_digit_adj.sv
// Single-nibble add-3 corrector for double-dabble; 4-bit result, no carry out.
module dd_digit_adj
    import dd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [3:0] nibble_adj
);

    always_comb begin
        nibble_adj = nibble;
        if (nibble >= ADD3_THRESH) begin
            nibble_adj = nibble + ADD3_VAL;
        end
    end

endmodule

// File: rtl/dd_bcd_sequencer.sv
// Sequenced binary-to-BCD converter (shift / add-3). Defining DD_FAST_ADJ_EN
// folds the add-3 step into the shift cycle, halving latency.
module dd_bcd_sequencer
    import dd_pkg::*;
#(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = clog2(BIN_W + 1);

    dd_state_e          state_q, state_d;
    logic [BIN_W-1:0]   bin_sr_q, bin_sr_d;
    logic [BCD_W-1:0]   work_q, work_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
    logic               overflow_q, overflow_d;

    logic [BCD_W-1:0]   work_adj;
    logic [BCD_W-1:0]   shift_src;
    logic [BCD_W-1:0]   work_shifted;
    logic [BCD_W-1:0]   all_nines;
    logic               ovf_next;
    dd_state_e          loop_state;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        dd_digit_adj u_adj (
            .nibble     (work_q[4*g +: 4]),
            .nibble_adj (work_adj[4*g +: 4])
        );
    end

`ifdef DD_FAST_ADJ_EN
    assign shift_src  = work_adj;
    assign loop_state = StShf;
`else
    assign shift_src  = work_q;
    assign loop_state = StAdj;
`endif

    assign work_shifted = {shift_src[BCD_W-2:0], bin_sr_q[BIN_W-1]};
    // Any bit leaving the top nibble means the value exceeded DIGITS digits.
    assign ovf_next     = ovf_acc_q | shift_src[BCD_W-1];

    always_comb begin
        all_nines = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            all_nines[4*i +: 4] = 4'd9;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            bin_sr_q   <= '0;
            work_q     <= '0;
            ovf_acc_q  <= 1'b0;
            cnt_q      <= '0;
            bcd_out_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_sr_q   <= bin_sr_d;
            work_q     <= work_d;
            ovf_acc_q  <= ovf_acc_d;
            cnt_q      <= cnt_d;
            bcd_out_q  <= bcd_out_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_sr_d   = bin_sr_q;
        work_d     = work_q;
        ovf_acc_d  = ovf_acc_q;
        cnt_d      = cnt_q;
        bcd_out_d  = bcd_out_q;
        overflow_d = overflow_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    bin_sr_d  = bin_in;
                    work_d    = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = CNT_W'(BIN_W);
                    state_d   = loop_state;
                end
            end
            StAdj: begin
                work_d  = work_adj;
                state_d = StShf;
            end
            StShf: begin
                bin_sr_d  = {bin_sr_q[BIN_W-2:0], 1'b0};
                work_d    = work_shifted;
                ovf_acc_d = ovf_next;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = StDone;
                    overflow_d = ovf_next;
                    bcd_out_d  = ovf_next ? all_nines : work_shifted;
                end else begin
                    state_d = loop_state;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        ready    = (state_q == StIdle);
        busy     = (state_q == StAdj) || (state_q == StShf);
        done     = (state_q == StDone);
        bcd_out  = bcd_out_q;
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_dd_bcd_sequencer.sv
// Scoreboard bench for dd_bcd_sequencer: a 3-digit and a 2-digit instance share
// stimulus; a decimal reference model predicts results and handshake timing.
module tb_dd_bcd_sequencer;

`ifdef DD_FAST_ADJ_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 16;
`endif

    typedef struct packed {
        logic [11:0] bcd;
        logic        ovf;
    } res_t;

    typedef struct packed {
        int unsigned epoch;
        res_t        r;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  bin_in;
    logic        ready0, busy0, done0, ovf0;
    logic [11:0] bcd0;
    logic        ready1, busy1, done1, ovf1;
    logic [7:0]  bcd1;

    always #5 clk = ~clk;

    dd_bcd_sequencer #(.BIN_W(8), .DIGITS(3)) u_dut (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .ready(ready0), .busy(busy0), .done(done0), .bcd_out(bcd0), .overflow(ovf0)
    );

    dd_bcd_sequencer #(.BIN_W(8), .DIGITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .ready(ready1), .busy(busy1), .done(done1), .bcd_out(bcd1), .overflow(ovf1)
    );

    // Decimal reference: digit extraction with %/ and saturation on overflow.
    function automatic res_t ref_conv(input int unsigned v, input int unsigned digits);
        res_t        e;
        int unsigned lim;
        int unsigned x;
        e   = '0;
        lim = 1;
        x   = v;
        for (int i = 0; i < int'(digits); i++) lim = lim * 10;
        if (v >= lim) begin
            e.ovf = 1'b1;
            for (int i = 0; i < int'(digits); i++) e.bcd[4*i +: 4] = 4'd9;
        end else begin
            for (int i = 0; i < int'(digits); i++) begin
                e.bcd[4*i +: 4] = 4'(x % 10);
                x = x / 10;
            end
        end
        return e;
    endfunction

    // Model state, written only by the posedge model process.
    bit          armed = 1'b0;
    bit          m_active = 1'b0;
    int          m_pos = 0;
    int unsigned epoch = 0;
    res_t        m_cur [2];
    res_t        m_held [2];
    sb_t         sb_mem [2][256];
    int unsigned wr_idx [2];

    // Monitor state.
    int unsigned rd_idx [2];
    int          n_checks = 0;
    int          n_fail = 0;
    bit          fin_req = 1'b0;

    initial begin
        wr_idx[0] = 0; wr_idx[1] = 0;
        rd_idx[0] = 0; rd_idx[1] = 0;
        m_held[0] = '0; m_held[1] = '0;
        m_cur[0] = '0; m_cur[1] = '0;
    end

    always @(posedge clk) begin
        armed = 1'b1;
        if (rst) begin
            m_active  = 1'b0;
            m_pos     = 0;
            epoch     = epoch + 1;
            m_held[0] = '0;
            m_held[1] = '0;
        end else if (m_active) begin
            m_pos = m_pos + 1;
            if (m_pos == LAT) begin
                m_held[0] = m_cur[0];
                m_held[1] = m_cur[1];
            end
            if (m_pos == LAT + 1) m_active = 1'b0;
        end else if (start) begin
            m_active = 1'b1;
            m_pos    = 0;
            m_cur[0] = ref_conv(int'(bin_in), 3);
            m_cur[1] = ref_conv(int'(bin_in), 2);
            for (int k = 0; k < 2; k++) begin
                sb_mem[k][wr_idx[k] % 256] = '{epoch: epoch, r: m_cur[k]};
                wr_idx[k] = wr_idx[k] + 1;
            end
        end
    end

    task automatic check(input int k, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %0h expected %0h at %0t", k, name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic        rdy, bsy, dn, ov;
        logic [11:0] bcd;
        sb_t         e;
        if (armed) begin
            for (int k = 0; k < 2; k++) begin
                if (k == 0) begin
                    rdy = ready0; bsy = busy0; dn = done0; bcd = bcd0; ov = ovf0;
                end else begin
                    rdy = ready1; bsy = busy1; dn = done1; bcd = {4'h0, bcd1}; ov = ovf1;
                end
                check(k, "ready", 32'(rdy), 32'(!m_active));
                check(k, "busy", 32'(bsy), 32'(m_active && m_pos < LAT));
                check(k, "done", 32'(dn), 32'(m_active && m_pos == LAT));
                if (dn) begin
                    while (rd_idx[k] != wr_idx[k] && sb_mem[k][rd_idx[k] % 256].epoch != epoch)
                        rd_idx[k] = rd_idx[k] + 1;
                    if (rd_idx[k] == wr_idx[k]) begin
                        check(k, "done_without_request", 32'd1, 32'd0);
                    end else begin
                        e = sb_mem[k][rd_idx[k] % 256];
                        rd_idx[k] = rd_idx[k] + 1;
                        check(k, "result_bcd", 32'(bcd), 32'(e.r.bcd));
                        check(k, "result_overflow", 32'(ov), 32'(e.r.ovf));
                    end
                end else begin
                    check(k, "held_bcd", 32'(bcd), 32'(m_held[k].bcd));
                    check(k, "held_overflow", 32'(ov), 32'(m_held[k].ovf));
                end
            end
        end
        if (fin_req) begin
            for (int k = 0; k < 2; k++) begin
                check(k, "scoreboard_drained", rd_idx[k], wr_idx[k]);
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic convert(input logic [7:0] v);
        start  = 1'b1;
        bin_in = v;
        tick();
        start  = 1'b0;
        bin_in = 8'($urandom);
        repeat (LAT + 3) tick();
    endtask

    initial begin
        logic [7:0] directed [7];
        directed = '{8'd255, 8'd0, 8'd99, 8'd100, 8'd42, 8'd128, 8'd173};
        rst    = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        foreach (directed[i]) convert(directed[i]);

        // Start held high: only values present on accepting edges count.
        start = 1'b1;
        repeat (100) begin
            bin_in = 8'($urandom);
            tick();
        end
        start = 1'b0;
        repeat (LAT + 3) tick();

        // Reset partway through a conversion aborts it.
        start  = 1'b1;
        bin_in = 8'd77;
        tick();
        start  = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        convert(8'd128);

        repeat (300) begin
            start  = ($urandom % 4) == 0;
            bin_in = 8'($urandom);
            tick();
        end
        start = 1'b0;
        repeat (LAT + 5) tick();
        convert(8'd200);

        fin_req = 1'b1;
        repeat (10) @(posedge clk);
        $display("FAIL summary_not_reached");
        $fatal(1);
    end

endmodule

// File: doc/dd_bcd_sequencer.md
Name: dd_bcd_sequencer

Overview:
- Sequenced binary-to-BCD converter using the double-dabble (shift / add-3) algorithm.
- Contains an FSM plus iteration counter that drive a shift register and per-digit add-3 correction.
- Handshake is start/ready in and done out. It sits between binary counters/arithmetic and 7-segment/BCD display logic.

Parameters:
- BIN_W, 8, width of binary input
- DIGITS, 3, number of BCD output digits (output width 4*DIGITS)

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a conversion; sampled only when ready=1
- bin_in  input  BIN_W  binary operand, captured on accepting edge
- ready  output  1  high in IDLE only
- busy  output  1  high while a conversion is in progress (ADJ/SHF states)
- done  output  1  one-cycle pulse, result valid
- bcd_out  output  4*DIGITS  packed BCD, digit 0 in [3:0]
- overflow  output  1  result did not fit in DIGITS digits

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; ready=1; busy=0; done=0; bcd_out=0; overflow=0.
  - Shift register and counter cleared.
  - Reset mid-conversion aborts it; no done pulse is produced.
- States: IDLE, ADJ, SHF, DONE.
- IDLE:
  - ready=1.
  - On start=1: load bin_in into the binary shift register, clear the BCD working register and ovf_acc, set cnt=BIN_W, go to ADJ.
- ADJ: each working nibble >=5 gets +3 (4-bit result, no carry between nibbles); go to SHF.
- SHF:
  - Shift {bcd_work, bin_sr} left by 1.
  - The bit shifted out of the top nibble ORs into ovf_acc.
  - cnt decrements. If cnt becomes 0, go to DONE; else go to ADJ.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - bcd_out and overflow are registered on the edge entering DONE.
  - If ovf_acc=1: overflow=1 and bcd_out saturates to all digits 9.
- Latency: done is high in the cycle following 2*BIN_W+1 rising edges after the accepting edge (default 17).
- Outputs hold their last result until the next conversion reaches DONE.
- start while not ready (ADJ/SHF/DONE) is ignored; no queuing.
- Back-to-back: start asserted during the DONE cycle is ignored. Start is accepted on the first IDLE cycle, so minimum issue interval is 2*BIN_W+2 cycles.
- bin_in is don't-care except on the accepting edge.
- rst has priority over start at the same edge.

Optional Feature:
- Macro: DD_FAST_ADJ_EN.
- Defined:
  - ADJ is merged into SHF: the add-3 result feeds the shift combinationally in one cycle.
  - FSM is IDLE/SHF/DONE; latency BIN_W+1 edges (default 9); minimum issue interval BIN_W+2.
- Undefined: the two-cycle ADJ/SHF scheme above, with shorter per-cycle logic depth.
- bcd_out and overflow results are identical in both modes.

Decomposition:
- Shared package dd_pkg:
  - State encoding localparams (IDLE=2'd0, ADJ=2'd1, SHF=2'd2, DONE=2'd3).
  - ADD3_THRESH=4'd5, ADD3_VAL=4'd3.
  - Counter-width helper function clog2(BIN_W+1).
- Sub-module dd_digit_adj: a single-nibble combinational add-3 corrector, instantiated DIGITS times via generate.

Test Plan:
- Defaults, bin_in=8'd255 with start pulse -> done exactly 17 edges after accept; bcd_out=12'h255; overflow=0; busy high throughout.
- bin_in=8'd0, then 8'd99 -> bcd_out=12'h000, then 12'h099; ready returns 1 the cycle after done.
- start held high continuously with bin_in changing every cycle -> only the value present at each accepting edge is converted; one done per 18 cycles; no spurious pulses.
- rst=1 for one edge at cycle 6 of a conversion -> no done; all outputs return to reset values; next conversion of 8'd128 gives 12'h128.
- BIN_W=8, DIGITS=2, bin_in=8'd100 -> overflow=1, bcd_out=8'h99; then bin_in=8'd42 -> overflow=0, bcd_out=8'h42.
- DD_FAST_ADJ_EN defined, bin_in=8'd173 -> done 9 edges after accept; bcd_out=12'h173.
